if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The parameter list SHALL be: NOP_INST, 32'h00000013, instruction word driven into the ID stage for every bubble.
REQ-002 Port clk_i SHALL be: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port rst_i SHALL be: input, 1 bit; reset is synchronous and active-high.
REQ-004 Port pc_i SHALL be: input, 32 bits, current fetch PC from the PC stage; value after reset is 32'hFFFFFFFC.
REQ-005 Port pc4_i SHALL be: input, 32 bits, pc_i+4 from the PC stage.
REQ-006 Port inst_i SHALL be: input, 32 bits, instruction word read combinationally from instruction memory at pc_i.
REQ-007 Port stall_i SHALL be: input, 1 bit, ID hazard stall; same signal drives PC keep_i.
REQ-008 Port flush_i SHALL be: input, 1 bit, redirect (branch or jump taken); same signal drives PC back_i.
REQ-009 Port id_pc_o SHALL be: output, 32 bits, registered PC of the instruction in ID.
REQ-010 Port id_pc4_o SHALL be: output, 32 bits, registered pc4 of the instruction in ID.
REQ-011 Port id_inst_o SHALL be: output, 32 bits, registered instruction, or NOP_INST when the slot is a bubble.
REQ-012 Port id_valid_o SHALL be: output, 1 bit, 1 when the ID slot holds a real fetched instruction.
REQ-013 Port id_misalign_o SHALL be: output, 1 bit, 1 when the valid ID instruction has pc[1:0] != 0.
REQ-014 Port bubble_cnt_o SHALL be: output, 32 bits, count of bubbles inserted (see Configuration).
REQ-015 Port stall_cnt_o SHALL be: output, 32 bits, count of stall cycles (see Configuration).

Function
REQ-016 The block SHALL contain a 2-state FSM. BOOT: the first PC value (-4) is a dummy. RUN: normal capture.
REQ-017 Each rising edge with rst_i=0 SHALL be resolved in the priority order flush_i, then stall_i, then capture.
REQ-018 When flush_i=1, the block SHALL set id_valid_o<=0, id_inst_o<=NOP_INST, id_pc_o<=0, id_pc4_o<=0 and id_misalign_o<=0, regardless of stall_i; the FSM state SHALL be unchanged.
REQ-019 When flush_i=0 and stall_i=1, every output register and the FSM state SHALL hold its value.
REQ-020 When flush_i=0, stall_i=0 and state=BOOT, the block SHALL load a bubble (as in REQ-018) and move to RUN.
REQ-021 When flush_i=0, stall_i=0 and state=RUN, the block SHALL capture id_pc_o<=pc_i, id_pc4_o<=pc4_i, id_inst_o<=inst_i, id_valid_o<=1 and id_misalign_o<=(pc_i[1:0]!=0).
REQ-022 Capture latency SHALL be exactly one cycle: the values present at edge N appear on the outputs after edge N.
REQ-023 A flush_i held high for k cycles SHALL produce k consecutive bubbles.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 When rst_i=1 at a rising edge, the block SHALL set state=BOOT, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0, id_pc4_o=0, id_misalign_o=0 and both counters to 0; reset SHALL override flush_i and stall_i.
REQ-026 A reset asserted in mid-operation SHALL discard the held instruction, and the next non-stalled edge SHALL be treated as BOOT.

Configuration
REQ-027 With macro IF_ID_PERF_EN defined, bubble_cnt_o SHALL increment by 1 on each edge that loads a bubble (REQ-018 or REQ-020), and stall_cnt_o SHALL increment by 1 on each edge with flush_i=0 and stall_i=1.
REQ-028 Both counters SHALL wrap modulo 2^32, and their increment SHALL be suppressed while rst_i=1.
REQ-029 Without IF_ID_PERF_EN, both counter ports SHALL remain present and be tied to 32'h0, and no counter flops SHALL be synthesized.

Verification
REQ-030 Reset then free-run with inst_i=pc_i^32'hA5A5A5A5: edge 1 SHALL give valid=0 and inst=0x13; edge 2 SHALL give pc=0, inst=0xA5A5A5A5, valid=1; edge 3 SHALL give pc=4.
REQ-031 With pc=8 in ID, stall_i=1 for 3 cycles: outputs SHALL hold pc=8 unchanged; with IF_ID_PERF_EN, stall_cnt_o SHALL increase by 3.
REQ-032 flush_i=1 and stall_i=1 in the same cycle: the next edge SHALL give valid=0, inst=0x13, pc=0; bubble_cnt_o+1, stall_cnt_o unchanged.
REQ-033 pc_i=32'h00000102 captured in RUN: id_misalign_o SHALL be 1; after a following flush it SHALL be 0.
REQ-034 rst_i pulsed while valid=1 and stall_i=1: the next edge SHALL give valid=0 and counters=0; the first non-stalled edge SHALL be a BOOT bubble.
REQ-035 Bench SHALL preset bubble_cnt_o to 32'hFFFFFFFF by force, then trigger one flush: bubble_cnt_o SHALL read 0; without the macro, both counters SHALL read 0 throughout.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Holds the fetched PC, PC+4 and instruction word for the decode stage.
// The first PC after reset (-4) is a dummy, so the first non-stalled edge
// after reset always loads a bubble. Flush takes priority over stall.
// Optional performance counters are enabled with the macro IF_ID_PERF_EN.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_misalign_o,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        load_bubble;
    logic        stall_event;

    // Next-state and next-slot contents: flush, then stall, then boot/capture.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        misalign_d  = misalign_q;
        load_bubble = 1'b0;
        stall_event = 1'b0;
        if (flush_i) begin
            load_bubble = 1'b1;
        end else if (stall_i) begin
            stall_event = 1'b1;
        end else if (state_q == BOOT) begin
            load_bubble = 1'b1;
            state_d     = RUN;
        end else begin
            pc_d       = pc_i;
            pc4_d      = pc4_i;
            inst_d     = inst_i;
            valid_d    = 1'b1;
            misalign_d = (pc_i[1:0] != 2'b00);
        end
        if (load_bubble) begin
            pc_d       = 32'h0;
            pc4_d      = 32'h0;
            inst_d     = NOP_INST;
            valid_d    = 1'b0;
            misalign_d = 1'b0;
        end
    end

    // Slot and FSM registers with synchronous reset to an empty BOOT slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= 32'h0;
            pc4_q      <= 32'h0;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign id_pc_o       = pc_q;
    assign id_pc4_o      = pc4_q;
    assign id_inst_o     = inst_q;
    assign id_valid_o    = valid_q;
    assign id_misalign_o = misalign_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (load_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (stall_event) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= 32'h0;
            stall_cnt_q  <= 32'h0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`else
    assign bubble_cnt_o = 32'h0;
    assign stall_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Testbench for if_id_reg: directed stimulus, a behavioural model of the
// decode slot checked every cycle, plus hand-computed literal checks.
module tb_if_id_reg;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] INST_KEY = 32'hA5A5A5A5;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] pc4_i;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_misalign_o;
    logic [31:0] bubble_cnt_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    if_id_reg #(.NOP_INST(NOP)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .pc4_i         (pc4_i),
        .inst_i        (inst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o),
        .id_misalign_o (id_misalign_o),
        .bubble_cnt_o  (bubble_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Behavioural model: the ID slot is either empty (bubble) or holds the
    // fetched pc/pc4/instruction; a fresh-from-reset pipeline discards one fetch.
    logic [31:0] m_pc, m_pc4, m_inst, m_bub, m_stl;
    logic        m_valid, m_mis, m_dummy_pending, m_ready;
    initial begin
        m_ready = 1'b0;
        m_dummy_pending = 1'b1;
        m_pc = 0; m_pc4 = 0; m_inst = NOP; m_valid = 0; m_mis = 0;
        m_bub = 0; m_stl = 0;
    end

    function automatic void model_empty_slot();
        m_pc = 0; m_pc4 = 0; m_inst = NOP; m_valid = 0; m_mis = 0;
`ifdef IF_ID_PERF_EN
        m_bub = m_bub + 1;
`endif
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_ready = 1'b1;
            m_dummy_pending = 1'b1;
            m_pc = 0; m_pc4 = 0; m_inst = NOP; m_valid = 0; m_mis = 0;
            m_bub = 0; m_stl = 0;
        end else if (flush_i) begin
            model_empty_slot();
        end else if (stall_i) begin
`ifdef IF_ID_PERF_EN
            m_stl = m_stl + 1;
`endif
        end else if (m_dummy_pending) begin
            m_dummy_pending = 1'b0;
            model_empty_slot();
        end else begin
            m_pc = pc_i; m_pc4 = pc4_i; m_inst = inst_i; m_valid = 1;
            m_mis = (pc_i % 4) != 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: checks every output against the model each cycle.
    always @(negedge clk_i) begin
        if (m_ready) begin
            checkOutput("model_pc", id_pc_o, m_pc);
            checkOutput("model_pc4", id_pc4_o, m_pc4);
            checkOutput("model_inst", id_inst_o, m_inst);
            checkOutput("model_valid", {31'b0, id_valid_o}, {31'b0, m_valid});
            checkOutput("model_misalign", {31'b0, id_misalign_o}, {31'b0, m_mis});
            checkOutput("model_bubble_cnt", bubble_cnt_o, m_bub);
            checkOutput("model_stall_cnt", stall_cnt_o, m_stl);
        end
    end

    // Drive one cycle of inputs (called at a falling edge), then wait for the
    // next falling edge so the edge's effect is visible.
    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input logic [31:0] pc);
        rst_i   = rst;
        stall_i = stall;
        flush_i = flush;
        pc_i    = pc;
        pc4_i   = pc + 32'd4;
        inst_i  = pc ^ INST_KEY;
        @(negedge clk_i);
    endtask

    logic [31:0] mis_pcs [3];
    logic [31:0] mis_exp [3];

    initial begin
        mis_pcs[0] = 32'h00001001; mis_exp[0] = 32'd1;
        mis_pcs[1] = 32'h00002003; mis_exp[1] = 32'd1;
        mis_pcs[2] = 32'h00004000; mis_exp[2] = 32'd0;

        rst_i = 1; stall_i = 0; flush_i = 0;
        pc_i = 32'hFFFFFFFC; pc4_i = 32'h0; inst_i = 32'hFFFFFFFC ^ INST_KEY;
        @(negedge clk_i);
        applyStimulus(1, 0, 0, 32'hFFFFFFFC);
        checkOutput("reset_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("reset_inst", id_inst_o, NOP);
        checkOutput("reset_pc", id_pc_o, 32'h0);
        checkOutput("reset_bubble_cnt", bubble_cnt_o, 32'h0);

        // Free run: dummy fetch, then pc 0, 4, 8.
        applyStimulus(0, 0, 0, 32'hFFFFFFFC);
        checkOutput("boot_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("boot_inst", id_inst_o, 32'h00000013);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("first_pc", id_pc_o, 32'h0);
        checkOutput("first_inst", id_inst_o, 32'hA5A5A5A5);
        checkOutput("first_valid", {31'b0, id_valid_o}, 32'd1);
        applyStimulus(0, 0, 0, 32'h4);
        checkOutput("second_pc", id_pc_o, 32'h4);
        checkOutput("second_pc4", id_pc4_o, 32'h8);
        applyStimulus(0, 0, 0, 32'h8);

        // Stall three cycles with pc 8 in ID.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'hC);
            checkOutput("stall_hold_pc", id_pc_o, 32'h8);
        end
`ifdef IF_ID_PERF_EN
        checkOutput("stall_cnt_after_3", stall_cnt_o, 32'd3);
        checkOutput("bubble_cnt_boot", bubble_cnt_o, 32'd1);
`endif
        applyStimulus(0, 0, 0, 32'hC);
        checkOutput("resume_pc", id_pc_o, 32'hC);

        // Flush and stall together: flush wins.
        applyStimulus(0, 1, 1, 32'h10);
        checkOutput("flush_stall_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("flush_stall_inst", id_inst_o, 32'h00000013);
        checkOutput("flush_stall_pc", id_pc_o, 32'h0);
`ifdef IF_ID_PERF_EN
        checkOutput("flush_stall_bubble_cnt", bubble_cnt_o, 32'd2);
        checkOutput("flush_stall_stall_cnt", stall_cnt_o, 32'd3);
`endif

        // Misaligned capture, then flush clears it; then a held flush.
        applyStimulus(0, 0, 0, 32'h00000102);
        checkOutput("misalign_set", {31'b0, id_misalign_o}, 32'd1);
        applyStimulus(0, 0, 1, 32'h00000106);
        checkOutput("misalign_cleared", {31'b0, id_misalign_o}, 32'd0);
        applyStimulus(0, 0, 1, 32'h00000200);
        applyStimulus(0, 0, 1, 32'h00000200);
`ifdef IF_ID_PERF_EN
        checkOutput("bubble_cnt_held_flush", bubble_cnt_o, 32'd5);
`endif

        // A few aligned/misaligned captures.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, mis_pcs[i]);
            checkOutput("misalign_table", {31'b0, id_misalign_o}, mis_exp[i]);
            checkOutput("inst_table", id_inst_o, mis_pcs[i] ^ INST_KEY);
        end

        // Reset pulse while valid and stalled.
        applyStimulus(1, 1, 0, 32'h00004004);
        checkOutput("midreset_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("midreset_bubble_cnt", bubble_cnt_o, 32'd0);
        checkOutput("midreset_stall_cnt", stall_cnt_o, 32'd0);
        applyStimulus(0, 1, 0, 32'h00000300);
        applyStimulus(0, 0, 0, 32'h00000300);
        checkOutput("post_reset_boot_valid", {31'b0, id_valid_o}, 32'd0);
        checkOutput("post_reset_boot_pc", id_pc_o, 32'h0);
        applyStimulus(0, 0, 0, 32'h00000304);
        checkOutput("post_reset_capture_pc", id_pc_o, 32'h00000304);

`ifdef IF_ID_PERF_EN
        // Preset the bubble counter to all-ones; one flush wraps it to zero.
        #1;
        force dut.bubble_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.bubble_cnt_q;
        m_bub = 32'hFFFFFFFF;
        applyStimulus(0, 0, 1, 32'h00000308);
        checkOutput("bubble_cnt_wrap", bubble_cnt_o, 32'h0);
`else
        applyStimulus(0, 0, 1, 32'h00000308);
        checkOutput("no_perf_bubble_cnt", bubble_cnt_o, 32'h0);
        checkOutput("no_perf_stall_cnt", stall_cnt_o, 32'h0);
`endif
        applyStimulus(0, 0, 0, 32'h00000400);
        checkOutput("final_pc", id_pc_o, 32'h00000400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
